triumph_wb_stage: RTL
=====================

Name: triumph_wb_stage

Overview:
- Writeback stage of the Triumph pipeline. Sole consumer of EX-stage ALU results and LSU load data.
- Merges the two result streams onto the single register-file write port.
- Buffers ALU results in a small FIFO while LSU writes take priority. Registers the zero flag of the last committed ALU result.
- Anti-starvation counter guarantees ALU results drain under continuous LSU traffic.

Parameters:
- DATA_W, 32, result/regfile data width
- ADDR_W, 5, register address width
- DEPTH, 2, ALU result FIFO depth; power of two, >=2
- STARVE_MAX, 4, consecutive cycles FIFO may stay full while LSU wins before LSU is throttled; >=1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- ex_valid_i  in  1  ALU result valid
- ex_ready_o  out  1  WB can accept ALU result
- ex_rd_i  in  ADDR_W  ALU destination register
- ex_data_i  in  DATA_W  ALU result
- ex_zero_i  in  1  ALU result==0 flag
- lsu_valid_i  in  1  load data valid
- lsu_ready_o  out  1  WB accepts load data this cycle
- lsu_rd_i  in  ADDR_W  load destination register
- lsu_data_i  in  DATA_W  load data
- rf_we_o  out  1  regfile write enable
- rf_waddr_o  out  ADDR_W  regfile write address
- rf_wdata_o  out  DATA_W  regfile write data
- flag_zero_wb_o  out  1  zero flag of last committed ALU result
- busy_o  out  1  FIFO non-empty

Interface: one clock, clk_i; reset rst_i is synchronous, active-high.

Behaviour:
- Reset (synchronous, rst_i high at posedge): FIFO emptied, pointers 0, starve counter 0. rf_we_o/rf_waddr_o/rf_wdata_o/flag_zero_wb_o/busy_o all 0. In-flight entries are discarded. Reset overrides all events in the same cycle.
- Handshakes are valid/ready. A transfer occurs on the posedge where both are high. Source must hold payload stable while valid && !ready.
- ex_ready_o = !full. Decided from full only: no push while full even if a pop happens the same cycle.
- lsu_ready_o = 1 except during a throttle cycle (see starvation).
- Commit select, each cycle, in priority order:
  1. LSU transfer.
  2. Else FIFO head (pop).
  3. Else nothing.
- Selected entry is registered into rf_* at the posedge, so rf_* outputs are registered.
- rf_we_o is high for exactly one cycle per committed entry with rd!=0. Entries with rd==0 are consumed, rf_we_o stays 0, and rf_waddr_o/rf_wdata_o hold their previous values.
- flag_zero_wb_o updates only when an ALU entry commits (including rd==0 entries). It holds across LSU commits.
- ALU latency: transfer edge E0 writes the FIFO; earliest commit edge is E1, so rf_we_o is high in the cycle after E1 (2 cycles).
- LSU latency: 1 cycle.
- Ordering: ALU entries commit in order. LSU may overtake queued ALU results. The ID hazard logic guarantees no same-rd conflict across the streams.
- Starvation counter:
  - Increments each cycle FIFO is full and an LSU transfer occurs; otherwise clears to 0.
  - When count==STARVE_MAX, lsu_ready_o=0 for that one cycle, the FIFO head commits, and the counter clears.
- Simultaneous push and pop with FIFO not full: both occur, occupancy unchanged.
- Pointer wrap: wraps modulo DEPTH. One extra pointer bit distinguishes full from empty.
- busy_o: registered FIFO non-empty status.

Optional Feature:
- Macro: TRIUMPH_WB_BYPASS_EN.
- Defined: when the FIFO is empty and no LSU transfer occurs, an ALU transfer commits directly at E0, bypassing the FIFO. rf_we_o is high in the next cycle (ALU latency 1).
- Undefined: every ALU result passes through the FIFO (latency 2).
- Port list is identical in both builds.

Decomposition:
- triumph_riscv_defines.v gets:
  - WB source encodings: `WB_SRC_NONE`, `WB_SRC_ALU`, `WB_SRC_LSU` (2 bits).
  - Default DATA_W/ADDR_W constants.
- One sub-module, triumph_wb_fifo: synchronous FIFO of {rd, data, zero}, parameterised DEPTH/width, with push, pop, full, empty.
- Arbitration and the starvation counter stay in triumph_wb_stage.

Test Plan:
- Reset mid-stream: FIFO holds 2 entries, rst_i pulsed -> next cycle rf_we_o=0, busy_o=0, ex_ready_o=1, and no later writes appear.
- Single ALU op: rd=3, data=0x0000_00A5, zero=0 -> rf_we_o high for exactly one cycle, waddr=3, wdata=0xA5, flag_zero_wb_o=0. High 2 cycles after the transfer (1 with TRIUMPH_WB_BYPASS_EN).
- Write to x0: rd=0, data=0, zero=1 -> rf_we_o stays 0, flag_zero_wb_o=1.
- Collision: ALU rd=5/0x11 and LSU rd=6/0x22 in the same cycle -> LSU write (6, 0x22) first, then ALU write (5, 0x11) on the following cycle.
- Full FIFO backpressure: LSU held valid, 3 ALU pushes with DEPTH=2 -> ex_ready_o=0 after the 2nd push. After STARVE_MAX=4 full cycles, lsu_ready_o=0 for one cycle and the ALU head commits.
- Wrap-around: 10 back-to-back ALU ops with data 1..10, no LSU -> 10 writes in order, data 1..10, none lost or duplicated.

Source files
------------

// File: rtl/triumph_wb_stage_pkg.sv
// triumph_wb_stage_pkg: shared writeback-stage constants and source encodings
package triumph_wb_stage_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LSU  = 2'd2
    } wb_src_e;
endpackage

// File: rtl/triumph_wb_stage_if.sv
// triumph_wb_stage_if: ALU/LSU result streams and regfile write port of the writeback stage
interface triumph_wb_stage_if import triumph_wb_stage_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [ADDR_W-1:0] ex_rd_i;
    logic [DATA_W-1:0] ex_data_i;
    logic              ex_zero_i;
    logic              lsu_valid_i;
    logic              lsu_ready_o;
    logic [ADDR_W-1:0] lsu_rd_i;
    logic [DATA_W-1:0] lsu_data_i;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic              flag_zero_wb_o;
    logic              busy_o;
    modport master (
        output ex_valid_i, ex_rd_i, ex_data_i, ex_zero_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  ex_ready_o, lsu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, flag_zero_wb_o, busy_o
    );
    modport slave (
        input  ex_valid_i, ex_rd_i, ex_data_i, ex_zero_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
        output ex_ready_o, lsu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, flag_zero_wb_o, busy_o
    );
endinterface

// File: rtl/triumph_wb_fifo.sv
// triumph_wb_fifo: synchronous FIFO of queued ALU results {rd, data, zero}
module triumph_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 38
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign rdata = mem[rp[AW-1:0]];
    // storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (push && !full) mem[wp[AW-1:0]] <= wdata;
    end
    // pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/triumph_wb_stage.sv
// triumph_wb_stage: merges ALU and LSU results onto the regfile write port; optional TRIUMPH_WB_BYPASS_EN lets ALU results skip an empty FIFO
module triumph_wb_stage import triumph_wb_stage_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    triumph_wb_stage_if.slave bus
);
    localparam int W  = ADDR_W + DATA_W + 1;
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0]     starve;
    logic              full, empty, throttle, lsu_xfer, ex_xfer, byp, push, pop;
    logic [W-1:0]      head;
    wb_src_e           src;
    logic [ADDR_W-1:0] c_rd;
    logic [DATA_W-1:0] c_data;
    logic              c_zero;
    triumph_wb_fifo #(.DEPTH(DEPTH), .W(W)) fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.ex_rd_i, bus.ex_data_i, bus.ex_zero_i}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    assign bus.ex_ready_o  = !full;
    assign bus.lsu_ready_o = !throttle;
    assign bus.busy_o      = !empty;
    // arbitration: LSU first, then FIFO head; a throttle cycle forces the head out
    always_comb begin
        throttle = starve == CW'(STARVE_MAX);
        lsu_xfer = bus.lsu_valid_i && !throttle;
        ex_xfer  = bus.ex_valid_i && !full;
`ifdef TRIUMPH_WB_BYPASS_EN
        byp      = ex_xfer && empty && !lsu_xfer;
`else
        byp      = 1'b0;
`endif
        pop      = !lsu_xfer && !empty;
        push     = ex_xfer && !byp;
        src      = lsu_xfer ? WB_SRC_LSU : (pop || byp) ? WB_SRC_ALU : WB_SRC_NONE;
        {c_rd, c_data, c_zero} = lsu_xfer ? {bus.lsu_rd_i, bus.lsu_data_i, 1'b0}
                               : pop      ? head
                               :            {bus.ex_rd_i, bus.ex_data_i, bus.ex_zero_i};
    end
    // registered commit; x0 writes are swallowed but still update the zero flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve             <= '0;
            bus.rf_we_o        <= 1'b0;
            bus.rf_waddr_o     <= '0;
            bus.rf_wdata_o     <= '0;
            bus.flag_zero_wb_o <= 1'b0;
        end else begin
            starve      <= (full && lsu_xfer) ? starve + CW'(1) : '0;
            bus.rf_we_o <= (src != WB_SRC_NONE) && (c_rd != '0);
            if ((src != WB_SRC_NONE) && (c_rd != '0)) begin
                bus.rf_waddr_o <= c_rd;
                bus.rf_wdata_o <= c_data;
            end
            if (src == WB_SRC_ALU) bus.flag_zero_wb_o <= c_zero;
        end
    end
endmodule
